// File: rtl/axi_read_initiator.sv
// axi_read_initiator: manager end of a single-outstanding read-burst link.
// Takes burst commands from a client, issues one address request each,
// consumes the data beats, and reports completion or protocol errors.
// Optional build macro: AXI_READ_INITIATOR_STATUS_EN adds the bursts_ok
// completion counter and the err_sticky flag.
module axi_read_initiator #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             arvalid,
  output logic [LEN_W-1:0] arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic             beat,
  output logic             done,
`ifdef AXI_READ_INITIATOR_STATUS_EN
  output logic             err,
  output logic [CNT_W-1:0] bursts_ok,
  output logic             err_sticky
`else
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] arlen_r;
  logic [LEN_W-1:0] remaining_r;
  logic             done_r;
  logic             err_r;

  // Handshake outputs are pure decodes of the registered state.
  assign cmd_ready = (state_r == IDLE);
  assign arvalid   = (state_r == ADDR);
  assign rready    = (state_r == DATA);
  assign beat      = rvalid & rready;
  assign arlen     = arlen_r;
  assign done      = done_r;
  assign err       = err_r;

  // Burst FSM: command latch, address phase, beat counting and rlast checking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      arlen_r     <= {LEN_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          // A beat with nothing outstanding is a target violation.
          if (rvalid) begin
            err_r <= 1'b1;
          end
          if (cmd_valid) begin
            arlen_r     <= cmd_len;
            remaining_r <= cmd_len;
            state_r     <= ADDR;
          end
        end
        ADDR: begin
          if (rvalid) begin
            err_r <= 1'b1;
          end
          if (arready) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            if (remaining_r == {LEN_W{1'b0}}) begin
              // Final expected beat: error unless it carries rlast.
              done_r  <= 1'b1;
              err_r   <= ~rlast;
              state_r <= IDLE;
            end else if (rlast) begin
              // Early rlast: abandon the rest of the burst.
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= IDLE;
            end else begin
              remaining_r <= remaining_r - {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef AXI_READ_INITIATOR_STATUS_EN
  logic [CNT_W-1:0] bursts_ok_r;
  logic             err_sticky_r;

  assign bursts_ok  = bursts_ok_r;
  assign err_sticky = err_sticky_r;

  // Status: saturating count of clean completions and a sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bursts_ok_r  <= {CNT_W{1'b0}};
      err_sticky_r <= 1'b0;
    end else begin
      if (done_r && !err_r && (bursts_ok_r != {CNT_W{1'b1}})) begin
        bursts_ok_r <= bursts_ok_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (err_r) begin
        err_sticky_r <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_initiator.sv
// Directed self-checking bench for axi_read_initiator. Expected error flags
// for each burst are queued when the burst is driven and popped on done.
module tb_axi_read_initiator;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             arvalid;
  logic [LEN_W-1:0] arlen;
  logic             arready;
  logic             rvalid;
  logic             rlast;
  logic             rready;
  logic             beat;
  logic             done;
  logic             err;
`ifdef AXI_READ_INITIATOR_STATUS_EN
  logic [CNT_W-1:0] bursts_ok;
  logic             err_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  axi_read_initiator #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .arvalid(arvalid), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .beat(beat), .done(done),
`ifdef AXI_READ_INITIATOR_STATUS_EN
    .err(err), .bursts_ok(bursts_ok), .err_sticky(err_sticky)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done, then compare err against the queued expectation.
  task automatic wait_done(input string tag);
    logic exp_err;
    bit   seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen && exp_q.size() > 0) begin
      exp_err = exp_q.pop_front();
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_rready_off"}, 32'(rready), 32'd0);
    end
  endtask

  // Full burst: command, one-cycle address phase, n_beats beats with rlast
  // on beat rlast_at (0 = never), and the completion check.
  task automatic burst(input string tag, input int len, input int n_beats,
                       input int rlast_at, input logic exp_err);
    step();
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    step();
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    check({tag, "_arvalid"}, 32'(arvalid), 32'd1);
    check({tag, "_arlen"}, 32'(arlen), 32'(len));
    step();
    arready = 1'b0;
    for (int i = 1; i <= n_beats; i++) begin
      rvalid = 1'b1;
      rlast  = (i == rlast_at);
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_arvalid_1cyc"}, 32'(arvalid), 32'd0);
      end
      check({tag, "_beat"}, 32'(beat), 32'd1);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    exp_q.push_back(exp_err);
    wait_done(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_arlen", 32'(arlen), 32'd0);
    step();
    rst_n = 1'b1;

    // Normal 4-beat burst, then single-beat burst.
    burst("len3", 3, 4, 4, 1'b0);
    burst("len0", 0, 1, 1, 1'b0);

    // Early rlast on beat 2 of 4; a further beat is not taken by the burst.
    burst("early", 3, 2, 2, 1'b1);
    rvalid = 1'b1;
    @(negedge clk);
    check("early_extra_beat", 32'(beat), 32'd0);
    step();
    rvalid = 1'b0;
    @(negedge clk);
    check("early_extra_err", 32'(err), 32'd1);
    check("early_extra_nodone", 32'(done), 32'd0);

    // Missing rlast: second (last) beat without rlast.
    burst("miss", 1, 2, 0, 1'b1);
    step();
    @(negedge clk);
    check("miss_idle", 32'(cmd_ready), 32'd1);

    // Address stall for 5 cycles with a spurious beat in ADDR.
    step();
    cmd_valid = 1'b1;
    cmd_len   = 8'd7;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rvalid = (c == 1);
      @(negedge clk);
      check("stall_arvalid", 32'(arvalid), 32'd1);
      check("stall_arlen", 32'(arlen), 32'd7);
      if (c == 1) check("stall_spur_beat", 32'(beat), 32'd0);
      if (c == 2) begin
        check("stall_spur_err", 32'(err), 32'd1);
        check("stall_spur_nodone", 32'(done), 32'd0);
      end
      step();
    end
    rvalid  = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    step();
    step();
    @(negedge clk);
    check("mid_rready", 32'(rready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rready", 32'(rready), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_arlen", 32'(arlen), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);

`ifdef AXI_READ_INITIATOR_STATUS_EN
    check("st_rst_ok", 32'(bursts_ok), 32'd0);
    check("st_rst_sticky", 32'(err_sticky), 32'd0);
    burst("st_a", 0, 1, 1, 1'b0);
    burst("st_b", 2, 3, 3, 1'b0);
    burst("st_c", 3, 2, 2, 1'b1);
    step();
    step();
    @(negedge clk);
    check("st_bursts_ok", 32'(bursts_ok), 32'd2);
    check("st_err_sticky", 32'(err_sticky), 32'd1);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
